matmul_seq: RTL
===============

# matmul_seq

Sequencer for the 2x2 matrix multiplier. It accepts matrices A and B as a stream of eight 8-bit words. It issues the four dot products C[i][j] = A[i][0]*B[0][j] + A[i][1]*B[1][j] to the existing `alu` through that block's start/complete handshake, buffers the four 18-bit results, and streams them out with valid/ready. It sits directly upstream of `alu`, driving `alu`'s row0/row1/col0/col1/start inputs and consuming its out/complete outputs.

## Interface
Parameters:
- `DW`, 8, operand width
- `OW`, 18, result width; must be ≥ 2*DW+1
- `TIMEOUT`, 64, maximum cycles spent in WAIT before the element is abandoned

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous and active-low; sampled on posedge, `rst`=0 resets.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DW: load stream, order a00,a01,a10,a11,b00,b01,b10,b11.
- `alu_start` out 1: one-cycle request to `alu`.
- `alu_row0` out DW, `alu_row1` out DW, `alu_col0` out DW, `alu_col1` out DW: ALU operands.
- `alu_out` in OW, `alu_complete` in 1: ALU result and done flag.
- `res_valid` out 1, `res_ready` in 1, `res_data` out OW: result stream.
- `res_idx` out 2: element index {i,j}.
- `res_last` out 1: high on idx 3.
- `busy` out 1: high in ISSUE, WAIT and DRAIN.
- `err` out 1: sticky timeout flag, cleared on the next accepted load word or on reset.

## Operation
- States: LOAD, ISSUE, WAIT, DRAIN.
- LOAD
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` edge stores `in_data` at load counter position 0..7, then increments the counter.
  - The accept of word 7 moves to ISSUE with element counter k=0.
  - `in_valid` gaps are allowed and simply stall.
- ISSUE
  - `alu_start`=1 for exactly one cycle, then WAIT.
  - Element k selects (i,j) = (k[1],k[0]).
  - Operand mapping: `alu_row0`=A[i][0], `alu_row1`=A[i][1], `alu_col0`=B[0][j], `alu_col1`=B[1][j].
  - Operands are driven from ISSUE through the end of WAIT and are held stable. In all other states they are 0.
- WAIT
  - `alu_complete` is sampled only in WAIT; a high value seen during the ISSUE cycle is ignored.
  - On `alu_complete`=1, `alu_out` is stored into C[k]. If k<3, increment k and go to ISSUE; else go to DRAIN.
  - Timeout: if the wait-cycle counter reaches TIMEOUT without complete, C[k]=0, `err`=1, and the sequencer proceeds as if complete.
- DRAIN
  - `res_valid`=1, `res_data`=C[n], `res_idx`=n, `res_last`=(n==3).
  - n advances on `res_valid`&`res_ready`.
  - Accepting n=3 returns to LOAD with the load counter cleared.
  - While `res_ready`=0, all result outputs hold.
- Arithmetic
  - Unsigned. Results are passed through unmodified; no saturation.
  - Maximum 2*255*255 = 130050 fits OW.
- Reset
  - All outputs 0.
  - State LOAD, all counters 0, C cleared.
  - `in_ready` is forced to 0 while `rst`=0.
  - Reset in any state, including mid-WAIT, discards all loaded data and results. No `alu_start` is issued afterwards until a fresh 8-word load completes.

## Timing
- The first accept can occur on the first posedge after `rst` returns high.
- Per element: 1 ISSUE cycle plus Lalu WAIT cycles, where Lalu ≥ 1 is the number of posedges from `alu_start` high to `alu_complete` sampled high.
- Total from the 8th load accept to the first `res_valid`: 4*(1+Lalu) cycles.
- Output rate is one result per cycle when `res_ready`=1. Full-throughput LOAD→LOAD is 8 + 4*(1+Lalu) + 4 cycles.
- No overlap: `in_ready`=0 during ISSUE, WAIT and DRAIN, so the next matrix load cannot begin until DRAIN finishes.
- `alu_start` never asserts in two consecutive cycles.

## Structure
- Package `matmul_pkg` holds:
  - the state enum `seq_state_t`;
  - `DW`/`OW` defaults;
  - the element-index constants and the load-order constants for A and B base offsets (0, 4).
- No sub-module. The result buffer is four OW registers inside `matmul_seq`.
- `alu` is instantiated beside this block at the top level, not inside it.

## Test plan
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], continuous load, `res_ready`=1 → results 19, 22, 43, 50 with idx 0..3 and `res_last` on 50; `err`=0.
- All operands 0xFF → four results of 130050, no overflow. Also check the operand pins: for k=2, row0=A10, row1=A11, col0=B00, col1=B10.
- `in_valid` toggled with random gaps during load; `res_ready` held low 3 cycles at idx 1 → `res_data`=22 is held stable throughout, no element is skipped or duplicated, and `alu_start` never pulses before the 8th accept.
- `rst`=0 asserted for one cycle mid-WAIT of k=1 → next cycle all outputs are 0 and the state is LOAD. A new load of identity A and B=[[9,8],[7,6]] yields 9, 8, 7, 6.
- ALU model that never completes for k=2 → after 64 WAIT cycles, `err`=1 and C[2]=0; other elements are correct. `err` clears on the next load accept.
- ALU model with `alu_complete` stuck high in the ISSUE cycle and latency 3 → the early complete is ignored, and results match the reference arithmetic.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
package matmul_pkg;

   typedef enum logic [1:0] {
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_DRAIN
   } seq_state_t;

   localparam int DW_DEF = 8;
   localparam int OW_DEF = 18;

   // Element index {i,j} of C.
   localparam logic [1:0] ELEM_00 = 2'd0;
   localparam logic [1:0] ELEM_01 = 2'd1;
   localparam logic [1:0] ELEM_10 = 2'd2;
   localparam logic [1:0] ELEM_11 = 2'd3;

   // Load-stream positions: A occupies words 0..3, B words 4..7, row-major.
   localparam logic [2:0] A_BASE    = 3'd0;
   localparam logic [2:0] B_BASE    = 3'd4;
   localparam logic [2:0] LOAD_LAST = 3'd7;

endpackage

// File: rtl/matmul_seq.sv
// Loads A and B as an 8-word stream, issues the four dot products to the
// external alu one at a time, then streams the buffered results out.
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int OW      = OW_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          alu_start,
   output logic [DW-1:0] alu_row0,
   output logic [DW-1:0] alu_row1,
   output logic [DW-1:0] alu_col0,
   output logic [DW-1:0] alu_col1,
   input  logic [OW-1:0] alu_out,
   input  logic          alu_complete,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [OW-1:0] res_data,
   output logic [1:0]    res_idx,
   output logic          res_last,
   output logic          busy,
   output logic          err
);

   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   seq_state_t     state_q, state_d;
   logic [2:0]     ld_cnt_q, ld_cnt_d;
   logic [1:0]     k_q, k_d;
   logic [1:0]     n_q, n_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic [DW-1:0]  mem_q [8];
   logic [DW-1:0]  mem_d [8];
   logic [OW-1:0]  c_q [4];
   logic [OW-1:0]  c_d [4];
   logic           err_q, err_d;
   logic           advance;

   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      k_d      = k_q;
      n_d      = n_q;
      wait_d   = wait_q;
      mem_d    = mem_q;
      c_d      = c_q;
      err_d    = err_q;
      advance  = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               mem_d[ld_cnt_q] = in_data;
               ld_cnt_d        = ld_cnt_q + 3'd1;
               err_d           = 1'b0;
               if (ld_cnt_q == LOAD_LAST) begin
                  state_d = S_ISSUE;
                  k_d     = ELEM_00;
               end
            end
         end
         S_ISSUE: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A timed-out element is recorded as zero and the sequence carries on.
            if (alu_complete) begin
               c_d[k_q] = alu_out;
               advance  = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               c_d[k_q] = '0;
               err_d    = 1'b1;
               advance  = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
            if (advance) begin
               if (k_q == ELEM_11) begin
                  state_d = S_DRAIN;
                  n_d     = ELEM_00;
               end else begin
                  k_d     = k_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               n_d = n_q + 2'd1;
               if (n_q == ELEM_11) begin
                  state_d  = S_LOAD;
                  ld_cnt_d = '0;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_LOAD;
         ld_cnt_q <= '0;
         k_q      <= '0;
         n_q      <= '0;
         wait_q   <= '0;
         mem_q    <= '{default: '0};
         c_q      <= '{default: '0};
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         k_q      <= k_d;
         n_q      <= n_d;
         wait_q   <= wait_d;
         mem_q    <= mem_d;
         c_q      <= c_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      in_ready  = rst && (state_q == S_LOAD);
      alu_start = (state_q == S_ISSUE);
      busy      = (state_q != S_LOAD);
      err       = err_q;
      alu_row0  = '0;
      alu_row1  = '0;
      alu_col0  = '0;
      alu_col1  = '0;
      res_valid = 1'b0;
      res_data  = '0;
      res_idx   = '0;
      res_last  = 1'b0;
      // Element k maps to (i,j) = (k[1],k[0]); row i of A against column j of B.
      if (state_q == S_ISSUE || state_q == S_WAIT) begin
         alu_row0 = mem_q[A_BASE + {1'b0, k_q[1], 1'b0}];
         alu_row1 = mem_q[A_BASE + {1'b0, k_q[1], 1'b1}];
         alu_col0 = mem_q[B_BASE + {2'b00, k_q[0]}];
         alu_col1 = mem_q[B_BASE + {2'b01, k_q[0]}];
      end
      if (state_q == S_DRAIN) begin
         res_valid = 1'b1;
         res_data  = c_q[n_q];
         res_idx   = n_q;
         res_last  = (n_q == ELEM_11);
      end
   end

endmodule
